cla16: RTL and testbench

CLA16 -- requirements
Module: cla16

---
 rtl/cla16.sv | 74 +++++++
 tb/tb_cla16.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cla16.sv
// cla16: 16-bit two-level carry-lookahead adder, optional output register (OUT_REG).
// Define CLA16_OVF_EN to add the signed-overflow output V.
module cla16 #(
  parameter int OUT_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout,
  output logic        PG,
  output logic        GG
`ifdef CLA16_OVF_EN
  ,
  output logic        V
`endif
);
  logic [15:0] p, g, s_c;
  logic [16:0] c;
  logic [3:0] sp, sg;
  logic gg_c;
  assign p = X ^ Y;
  assign g = X & Y;
  for (genvar i = 0; i < 4; i++) begin : g_slice
    logic [3:0] pi, gi;
    logic ci;
    assign pi = p[4*i +: 4];
    assign gi = g[4*i +: 4];
    assign ci = c[4*i];
    assign c[4*i+1] = gi[0] | pi[0] & ci;
    assign c[4*i+2] = gi[1] | pi[1] & gi[0] | pi[1] & pi[0] & ci;
    assign c[4*i+3] = gi[2] | pi[2] & gi[1] | pi[2] & pi[1] & gi[0] | pi[2] & pi[1] & pi[0] & ci;
    assign sp[i] = &pi;
    assign sg[i] = gi[3] | pi[3] & gi[2] | pi[3] & pi[2] & gi[1] | pi[3] & pi[2] & pi[1] & gi[0];
  end
  // Slice carry-ins come straight from group P/G, never from a neighbouring slice.
  assign c[0]  = Cin;
  assign c[4]  = sg[0] | sp[0] & Cin;
  assign c[8]  = sg[1] | sp[1] & sg[0] | sp[1] & sp[0] & Cin;
  assign c[12] = sg[2] | sp[2] & sg[1] | sp[2] & sp[1] & sg[0] | sp[2] & sp[1] & sp[0] & Cin;
  assign gg_c  = sg[3] | sp[3] & sg[2] | sp[3] & sp[2] & sg[1] | sp[3] & sp[2] & sp[1] & sg[0];
  assign c[16] = gg_c | (&sp) & Cin;
  assign s_c   = p ^ c[15:0];
  if (OUT_REG != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        S    <= '0;
        Cout <= 1'b0;
        PG   <= 1'b0;
        GG   <= 1'b0;
`ifdef CLA16_OVF_EN
        V    <= 1'b0;
`endif
      end else begin
        S    <= s_c;
        Cout <= c[16];
        PG   <= &sp;
        GG   <= gg_c;
`ifdef CLA16_OVF_EN
        V    <= c[16] ^ c[15];
`endif
      end
  end else begin : g_comb
    assign S    = s_c;
    assign Cout = c[16];
    assign PG   = &sp;
    assign GG   = gg_c;
`ifdef CLA16_OVF_EN
    assign V    = c[16] ^ c[15];
`endif
  end
endmodule

// File: tb/tb_cla16.sv
// tb_cla16: scoreboard bench for registered and combinational cla16 against arithmetic X+Y+Cin.
module tb_cla16;
  typedef struct {
    logic [15:0] s;
    logic co, pg, gg, v;
  } exp_t;
  logic clk = 0, rst = 1, Cin = 0;
  logic [15:0] X = 0, Y = 0;
  logic [15:0] s_r, s_c;
  logic co_r, pg_r, gg_r, co_c, pg_c, gg_c, v_r, v_c;
  int total = 0, passed = 0;
  exp_t q[$];
  always #5 clk = ~clk;
`ifndef CLA16_OVF_EN
  assign v_r = 1'b0;
  assign v_c = 1'b0;
`endif
  cla16 #(.OUT_REG(1)) u_reg (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .Cin(Cin),
    .S(s_r), .Cout(co_r), .PG(pg_r), .GG(gg_r)
`ifdef CLA16_OVF_EN
    , .V(v_r)
`endif
  );
  cla16 #(.OUT_REG(0)) u_comb (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .Cin(Cin),
    .S(s_c), .Cout(co_c), .PG(pg_c), .GG(gg_c)
`ifdef CLA16_OVF_EN
    , .V(v_c)
`endif
  );
  function automatic exp_t model(input logic [15:0] x, y, input logic ci);
    exp_t e;
    int t, sv;
    t = int'(x) + int'(y) + int'(ci);
    sv = int'($signed(x)) + int'($signed(y)) + int'(ci);
    e.s = t[15:0];
    e.co = t[16];
    e.pg = (x ^ y) == 16'hFFFF;
    e.gg = int'(x) + int'(y) > 65535;
    e.v = sv > 32767 || sv < -32768;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask
  task automatic vec(input logic [15:0] x, y, input logic ci);
    @(negedge clk);
    X = x;
    Y = y;
    Cin = ci;
    q.push_back(model(x, y, ci));
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("reg S", 32'(s_r), 32'(e.s));
      chk("reg Cout", 32'(co_r), 32'(e.co));
      chk("reg PG", 32'(pg_r), 32'(e.pg));
      chk("reg GG", 32'(gg_r), 32'(e.gg));
      chk("comb S", 32'(s_c), 32'(e.s));
      chk("comb Cout", 32'(co_c), 32'(e.co));
      chk("comb PG", 32'(pg_c), 32'(e.pg));
      chk("comb GG", 32'(gg_c), 32'(e.gg));
`ifdef CLA16_OVF_EN
      chk("reg V", 32'(v_r), 32'(e.v));
      chk("comb V", 32'(v_c), 32'(e.v));
`endif
    end
  end
  initial begin
    logic [15:0] x, y;
    #2;
    chk("reset S", 32'(s_r), 0);
    chk("reset flags", {co_r, pg_r, gg_r, v_r}, 0);
    @(negedge clk) rst = 0;
    vec(16'hFFFF, 16'h0001, 0);
    vec(16'hFFFF, 16'h0000, 1);
    vec(16'h7FFF, 16'h0001, 0);
    vec(16'h8000, 16'h8000, 0);
    vec(16'h0000, 16'h0000, 0);
    vec(16'hFFFF, 16'hFFFF, 1);
    for (int j = 0; j < 1000; j++) vec(16'(j), 16'(16'hDDDD - j), 0);
    // Async reset mid-stream: outputs clear without a clock edge.
    @(negedge clk);
    X = 16'h1234;
    Y = 16'h1111;
    Cin = 0;
    #2 rst = 1;
    #1;
    chk("async rst S", 32'(s_r), 0);
    chk("async rst flags", {co_r, pg_r, gg_r, v_r}, 0);
    @(posedge clk);
    #2;
    chk("held rst S", 32'(s_r), 0);
    @(negedge clk) rst = 0;
    q.push_back(model(16'h1234, 16'h1111, 0));
    @(posedge clk);
    #2;
    chk("post rst S", 32'(s_r), 32'h2345);
    for (int k = 0; k < 4000; k++) begin
      x = 16'($urandom);
      case ($urandom_range(3))
        0: y = ~x;
        1: y = 16'(-x);
        default: y = 16'($urandom);
      endcase
      vec(x, y, 1'($urandom));
    end
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
